// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle ARM-subset controller: FSM states,
// ALU operations, mux selects, opcode/cmd fields and condition codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECR    = 4'd6,
        ST_EXECI    = 4'd7,
        ST_ALUWB    = 4'd8,
        ST_BRANCH   = 4'd9
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_ORR = 4'b1100;
    localparam logic [3:0] ALU_MOV = 4'b1101;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;
    localparam logic [1:0] SRCB_ZERO = 2'd3;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_RDATA  = 2'd1;
    localparam logic [1:0] RES_ALURES = 2'd2;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_AL = 4'b1110;

    function automatic logic cmd_supported(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CMD_AND, CMD_SUB, CMD_ADD, CMD_CMP, CMD_ORR, CMD_MOV: ok = 1'b1;
            default:                                              ok = 1'b0;
        endcase
        return ok;
    endfunction

    // CMP is a subtract whose only visible effect is on the Z flag.
    function automatic logic [3:0] alu_of_cmd(input logic [3:0] cmd);
        logic [3:0] op;
        case (cmd)
            CMD_AND: op = ALU_AND;
            CMD_SUB: op = ALU_SUB;
            CMD_ADD: op = ALU_ADD;
            CMD_CMP: op = ALU_SUB;
            CMD_ORR: op = ALU_ORR;
            CMD_MOV: op = ALU_MOV;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_controller_condition_check.sv
// Condition-code evaluator: EQ, NE and AL are the only codes that can pass.
import mc_ctrl_pkg::*;

module condition_check (
    input  logic [3:0] cond,
    input  logic       ZFlag,
    output logic       pass
);

    // Map the condition field against the architectural Z flag.
    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = ZFlag;
            COND_NE: pass = ~ZFlag;
            COND_AL: pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for the multicycle ARM-subset datapath.
// Optional macro MULTICYCLE_CTRL_BL_EN enables branch-with-link (R14 write).
import mc_ctrl_pkg::*;

module multicycle_controller (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] INSTR,
    input  logic        FlagZ,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        AdSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        Sel14,
    output logic [3:0]  STATE,
    output logic        ZFlag
);

    state_t     state_r;
    state_t     next_s;
    state_t     eff_state_s;
    logic       zflag_r;
    logic       pass_s;
    logic [1:0] op_s;
    logic [3:0] cmd_s;
    logic       is_dp_s, is_mem_s, is_br_s, is_cmp_s;
    logic       imm_bit_s, sbit_s, lbit_s, ubit_s, link_en_s;
    logic       undefined_s;
    logic       unused_s;

    assign op_s      = INSTR[27:26];
    assign cmd_s     = INSTR[24:21];
    assign imm_bit_s = INSTR[25];
    assign sbit_s    = INSTR[20];
    assign lbit_s    = INSTR[20];
    assign ubit_s    = INSTR[23];
    assign is_dp_s   = (op_s == OP_DP);
    assign is_mem_s  = (op_s == OP_MEM);
    assign is_br_s   = (op_s == OP_BR);
    assign is_cmp_s  = (cmd_s == CMD_CMP);
    assign undefined_s = (op_s == 2'b11) | (is_dp_s & ~cmd_supported(cmd_s));
    assign unused_s  = ^INSTR[19:0];

`ifdef MULTICYCLE_CTRL_BL_EN
    assign link_en_s = INSTR[24];
`else
    assign link_en_s = 1'b0;
`endif

    condition_check u_cond (
        .cond  (INSTR[31:28]),
        .ZFlag (zflag_r),
        .pass  (pass_s)
    );

    assign STATE  = state_r;
    assign ZFlag  = zflag_r;
    assign RegSrc = {is_mem_s & ~lbit_s, is_br_s};

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= next_s;
        end
    end

    // Architectural Z flag, written only on flag-setting ALU writeback.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            zflag_r <= 1'b0;
        end else if ((state_r == ST_ALUWB) && (sbit_s | is_cmp_s)) begin
            zflag_r <= FlagZ;
        end else begin
            zflag_r <= zflag_r;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = ST_FETCH;
        case (state_r)
            ST_FETCH:  next_s = ST_DECODE;
            ST_DECODE: begin
                if (~pass_s | undefined_s) begin
                    next_s = ST_FETCH;
                end else if (is_mem_s) begin
                    next_s = ST_MEMADR;
                end else if (is_br_s) begin
                    next_s = ST_BRANCH;
                end else if (imm_bit_s) begin
                    next_s = ST_EXECI;
                end else begin
                    next_s = ST_EXECR;
                end
            end
            ST_MEMADR: begin
                if (lbit_s) begin
                    next_s = ST_MEMREAD;
                end else begin
                    next_s = ST_MEMWRITE;
                end
            end
            ST_MEMREAD:  next_s = ST_MEMWB;
            ST_MEMWB:    next_s = ST_FETCH;
            ST_MEMWRITE: next_s = ST_FETCH;
            ST_EXECR:    next_s = ST_ALUWB;
            ST_EXECI:    next_s = ST_ALUWB;
            ST_ALUWB:    next_s = ST_FETCH;
            ST_BRANCH:   next_s = ST_FETCH;
            default:     next_s = ST_FETCH;
        endcase
    end

    // While RESET is high the outputs show FETCH with all write strobes low.
    assign eff_state_s = RESET ? ST_FETCH : state_r;

    // Moore output decode.
    always_comb begin
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        AdSrc      = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ResultSrc  = RES_ALUOUT;
        ALUControl = ALU_AND;
        Sel14      = 1'b0;
        case (op_s)
            OP_MEM:  ImmSrc = IMM_MEM;
            OP_BR:   ImmSrc = IMM_BR;
            default: ImmSrc = IMM_DP;
        endcase
        case (eff_state_s)
            ST_FETCH: begin
                IRWrite    = ~RESET;
                PCWrite    = ~RESET;
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
            end
            ST_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
            end
            ST_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ubit_s ? ALU_ADD : ALU_SUB;
            end
            ST_MEMREAD: begin
                AdSrc = 1'b1;
            end
            ST_MEMWB: begin
                ResultSrc = RES_RDATA;
                RegWrite  = 1'b1;
            end
            ST_MEMWRITE: begin
                AdSrc    = 1'b1;
                MemWrite = 1'b1;
            end
            ST_EXECR: begin
                ALUControl = alu_of_cmd(cmd_s);
            end
            ST_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_of_cmd(cmd_s);
            end
            ST_ALUWB: begin
                RegWrite = ~is_cmp_s;
            end
            ST_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = ALU_ADD;
                ResultSrc  = RES_ALURES;
                PCWrite    = 1'b1;
                Sel14      = link_en_s;
                RegWrite   = link_en_s;
            end
            default: begin
                RegWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control unit for the multicycle ARM-subset datapath: a Moore FSM that reads the latched instruction word and the registered Z flag.
- Drives every datapath enable and mux select: RegWrite, MemWrite, IRWrite, PCWrite, AdSrc, ALUSrcA/B, ResultSrc, RegSrc, ImmSrc, ALUControl, Sel14.
- Keeps its own architectural Z flag and evaluates condition codes.
- Sits beside the datapath at processor top level.

Parameters:
- none (encodings fixed in package)

Ports:
- CLK  input  1  system clock, rising edge
- RESET  input  1  synchronous, active-high reset
- INSTR  input  32  instruction register contents from datapath
- FlagZ  input  1  registered Z of previous cycle's ALU result
- RegWrite  output  1  register file write enable
- MemWrite  output  1  memory write enable
- IRWrite  output  1  instruction register load
- PCWrite  output  1  PC load
- AdSrc  output  1  0=PC, 1=Result as memory address
- ALUSrcA  output  1  0=RD1 reg, 1=PC
- ALUSrcB  output  2  0=shifted RD2, 1=ExtImm, 2=const 4, 3=zero
- ResultSrc  output  2  0=ALUOut, 1=ReadData reg, 2=ALUResult
- RegSrc  output  2  [0]=1: RA1=R15; [1]=1: RA2=Rd
- ImmSrc  output  2  00 imm8 (DP), 01 imm12 (mem), 10 imm24 (branch)
- ALUControl  output  4  AND 0000, SUB 0010, ADD 0100, ORR 1100, MOV 1101
- Sel14  output  1  RA3=R14 and WD3=PC (link write)
- STATE  output  4  current FSM state, debug
- ZFlag  output  1  architectural Z flag

Behaviour:
- Reset:
  - state=FETCH, ZFlag=0.
  - While RESET=1, RegWrite/MemWrite/IRWrite/PCWrite/Sel14 are forced 0. Other outputs follow the FETCH values.
  - RESET mid-instruction aborts it; the next cycle after RESET falls is FETCH.
- Decode, combinational from INSTR:
  - Op=INSTR[27:26].
  - DP: Op=00, I=INSTR[25], cmd=INSTR[24:21], S=INSTR[20].
  - MEM: Op=01, L=INSTR[20], U=INSTR[23].
  - BR: Op=10, link=INSTR[24].
  - Supported cmds are AND, SUB, ADD, ORR, MOV and CMP (1010, mapped to ALU SUB, no register write). Any other cmd, or Op=11, is undefined.
  - RegSrc[0]=BR; RegSrc[1]=MEM & ~L.
  - ImmSrc set by Op, held in every state.
- Condition INSTR[31:28]:
  - EQ (0000) passes when ZFlag=1.
  - NE (0001) passes when ZFlag=0.
  - AL (1110) always passes.
  - All other codes fail.
- FSM states, with outputs not listed defaulting to 0:
  - FETCH: AdSrc=0, IRWrite, ALUSrcA=1, ALUSrcB=2, ADD, ResultSrc=2, PCWrite. Next: DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=2, ADD. If the condition fails or the instruction is undefined, next is FETCH. Otherwise MEM→MEMADR, DP&I→EXECI, DP&~I→EXECR, BR→BRANCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=1, ADD if U else SUB. Next: L ? MEMREAD : MEMWRITE.
  - MEMREAD: ResultSrc=0, AdSrc=1. Next: MEMWB.
  - MEMWB: ResultSrc=1, RegWrite. Next: FETCH.
  - MEMWRITE: ResultSrc=0, AdSrc=1, MemWrite. Next: FETCH.
  - EXECR: ALUSrcA=0, ALUSrcB=0, ALUControl=cmd map. Next: ALUWB.
  - EXECI: as EXECR but ALUSrcB=1. Next: ALUWB.
  - ALUWB: ResultSrc=0. RegWrite unless CMP. If S=1 or CMP, ZFlag<=FlagZ at the clock edge. Next: FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=1, ADD, ResultSrc=2, PCWrite. If link, also Sel14=1 and RegWrite=1, so R14<=PC (the fetch-incremented PC). Next: FETCH.
- Cycle counts:
  - LDR 5
  - STR 4
  - DP/CMP 4
  - B/BL 3
  - condition-failed or undefined 2
- Rd=15 on DP/LDR: RegWrite is asserted normally and the PC is unaffected.
- ZFlag updates only in ALUWB. A condition in DECODE sees the value written by the prior instruction.

Optional Feature:
- Macro MULTICYCLE_CTRL_BL_EN.
- Defined: link bit honoured in BRANCH (Sel14=1, RegWrite=1).
- Undefined: link bit ignored; BL behaves as B; Sel14 is constant 0.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum (FETCH..BRANCH, 4-bit)
  - ALU op codes
  - ALUSrcB/ResultSrc/ImmSrc encodings
  - Op and cmd constants, condition codes
- Sub-module condition_check: combinational; inputs cond[3:0] and ZFlag; output pass.

Test Plan:
- RESET high 2 cycles, then low → STATE=FETCH; PCWrite=0/IRWrite=0 during reset; PCWrite=1 and IRWrite=1 in the first post-reset cycle.
- INSTR=0xE2801005 (ADD imm) → FETCH, DECODE, EXECI (ALUSrcB=1, ALUControl=0100), ALUWB (RegWrite=1); 4 cycles.
- INSTR=0xE1500001 (CMP) with FlagZ=1 in ALUWB → RegWrite=0, ZFlag becomes 1. Then 0x0A000002 (BEQ) → BRANCH with PCWrite=1. Then 0x1A000002 (BNE) → DECODE→FETCH, PCWrite=0 in DECODE.
- INSTR=0xE5912004 (LDR) → MEMADR ADD, MEMREAD AdSrc=1, MEMWB ResultSrc=1 RegWrite=1; 5 cycles. INSTR=0xE5012004 (STR, U=0) → MEMADR ALUControl=0010, MEMWRITE MemWrite=1, RegSrc=10.
- INSTR=0xEB000003 (BL) with macro → BRANCH: Sel14=1, RegWrite=1, RegSrc=01, ImmSrc=10. Without macro → Sel14=0, RegWrite=0.
- RESET asserted in MEMREAD → MemWrite/RegWrite stay 0; FETCH follows; ZFlag=0.
